// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;
   localparam int BCD_DIGIT_W = 4;
   // Digits of 2^w-1 = floor(w*log10(2))+1; the fixed-point log10(2) is exact enough for any practical width.
   function automatic int dec_digits_for(input int bin_width);
      return (bin_width * 30103) / 100000 + 1;
   endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble add-3 correction for one BCD digit.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_in,
   output logic [BCD_DIGIT_W-1:0] d_out
);
   assign d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
endmodule

// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: one-bit-per-clock double-dabble converter with valid/ready handshakes,
// overflow detection and leading-zero blanking.
module seq_bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH  = 16,
   parameter int DEC_DIGITS = 5,
   parameter int BLANK_LZ   = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BIN_WIDTH-1:0]              bin,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BCD_DIGIT_W*DEC_DIGITS-1:0] bcd,
   output logic [DEC_DIGITS-1:0]             blank,
   output logic                              overflow
);
   localparam int AW = BCD_DIGIT_W * DEC_DIGITS;
   localparam int CW = $clog2(BIN_WIDTH + 1);

   if (BIN_WIDTH < 2 || DEC_DIGITS < 1) begin : g_param_check
      $error("seq_bin_to_bcd: BIN_WIDTH must be >=2 and DEC_DIGITS >=1");
   end

   b2b_state_t           state_q, state_d;
   logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
   logic [AW-1:0]        acc_q, acc_d, adj, acc_shift;
   logic                 ovf_q, ovf_d, ovf_shift, zero_run;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        bcd_q, bcd_d;
   logic [DEC_DIGITS-1:0] blank_q, blank_d, blank_calc;
   logic                 overflow_q, overflow_d;

   for (genvar g = 0; g < DEC_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .d_in  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .d_out (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign acc_shift = {adj[AW-2:0], shreg_q[BIN_WIDTH-1]};
   // Any bit pushed out of the top digit means the value no longer fits in DEC_DIGITS.
   assign ovf_shift = ovf_q | adj[AW-1];

   always_comb begin
      blank_calc = '0;
      zero_run   = 1'b1;
      for (int i = DEC_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         blank_calc[i] = zero_run && !ovf_shift && (BLANK_LZ != 0);
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: if (in_valid) begin
            shreg_d = bin;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CW'(BIN_WIDTH);
            state_d = SHIFT;
         end
         SHIFT: begin
            shreg_d = shreg_q << 1;
            acc_d   = acc_shift;
            ovf_d   = ovf_shift;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d    = DONE;
               bcd_d      = acc_shift;
               blank_d    = blank_calc;
               overflow_d = ovf_shift;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         blank_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         blank_q    <= blank_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign bcd       = bcd_q;
   assign blank     = blank_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb_seq_bin_to_bcd: directed and random checks of seq_bin_to_bcd against an arithmetic decimal model.
module tb_seq_bin_to_bcd;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] bin = '0;
   logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
   logic [7:0]  s_bin = '0;
   logic        in_ready5, out_valid5, overflow5;
   logic [19:0] bcd5;
   logic [4:0]  blank5;
   logic        in_ready4, out_valid4, overflow4;
   logic [15:0] bcd4;
   logic [3:0]  blank4;
   logic        s_in_ready, s_out_valid, s_overflow;
   logic [11:0] s_bcd;
   logic [2:0]  s_blank;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   seq_bin_to_bcd u_d5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .bin(bin),
      .out_valid(out_valid5), .out_ready(out_ready), .bcd(bcd5), .blank(blank5), .overflow(overflow5));
   seq_bin_to_bcd #(.DEC_DIGITS(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .bin(bin),
      .out_valid(out_valid4), .out_ready(out_ready), .bcd(bcd4), .blank(blank4), .overflow(overflow4));
   seq_bin_to_bcd #(.BIN_WIDTH(8), .DEC_DIGITS(3)) u_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin(s_bin),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd(s_bcd), .blank(s_blank), .overflow(s_overflow));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Decimal view of v: low d digits, overflow if v >= 10^d, blank[i] iff the kept value < 10^i.
   task automatic model(input longint v, input int d, output logic [19:0] e_bcd,
                        output logic [4:0] e_blank, output logic e_ovf);
      longint lim = 1, m, p = 1;
      for (int i = 0; i < d; i++) lim *= 10;
      m = v % lim;
      e_ovf = (v >= lim);
      e_bcd = '0;
      e_blank = '0;
      for (int i = 0; i < d; i++) begin
         e_bcd[4*i +: 4] = 4'((m / p) % 10);
         e_blank[i] = (i >= 1) && !e_ovf && (m < p);
         p *= 10;
      end
   endtask

   task automatic start16(input logic [15:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      bin = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
      bin = 16'($urandom);
   endtask

   task automatic wait_done16(output int n);
      n = 0;
      while (!out_valid5 && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   task automatic check16(input logic [15:0] v, input string tag);
      logic [19:0] eb;
      logic [4:0]  ek;
      logic        eo;
      model(v, 5, eb, ek, eo);
      chk({tag, "_valid5"}, 32'(out_valid5), 32'd1);
      chk({tag, "_bcd5"}, 32'(bcd5), 32'(eb));
      chk({tag, "_blank5"}, 32'(blank5), 32'(ek));
      chk({tag, "_ovf5"}, 32'(overflow5), 32'(eo));
      model(v, 4, eb, ek, eo);
      chk({tag, "_valid4"}, 32'(out_valid4), 32'd1);
      chk({tag, "_bcd4"}, 32'(bcd4), 32'(eb));
      chk({tag, "_blank4"}, 32'(blank4), 32'(ek));
      chk({tag, "_ovf4"}, 32'(overflow4), 32'(eo));
   endtask

   task automatic pop16(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, "_pop_in_ready"}, 32'(in_ready5), 32'd1);
      chk({tag, "_pop_out_valid"}, 32'(out_valid5), 32'd0);
   endtask

   task automatic conv16(input logic [15:0] v, input string tag);
      int n;
      start16(v);
      chk({tag, "_busy"}, 32'(in_ready5), 32'd0);
      wait_done16(n);
      chk({tag, "_latency"}, 32'(n), 32'd16);
      check16(v, tag);
      pop16(tag);
   endtask

   task automatic conv8(input logic [7:0] v);
      int n = 0;
      logic [19:0] eb;
      logic [4:0]  ek;
      logic        eo;
      @(negedge clk);
      s_in_valid = 1'b1;
      s_bin = v;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      s_bin = 8'($urandom);
      while (!s_out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      model(longint'(v), 3, eb, ek, eo);
      chk("s_latency", 32'(n), 32'd8);
      chk("s_bcd", 32'(s_bcd), 32'(eb));
      chk("s_blank", 32'(s_blank), 32'(ek));
      chk("s_ovf", 32'(s_overflow), 32'(eo));
      @(negedge clk);
      s_out_ready = 1'b1;
      @(posedge clk);
      #1 s_out_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic [19:0] held;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready5), 32'd1);
      chk("rst_out_valid", 32'(out_valid5), 32'd0);
      chk("rst_bcd", 32'(bcd5), 32'd0);
      chk("rst_blank", 32'(blank5), 32'd0);
      chk("rst_ovf", 32'(overflow5), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("idle_out_ready_noop", 32'(out_valid5), 32'd0);
      conv16(16'd255, "v255");
      conv16(16'd0, "v0");
      conv16(16'd65535, "v65535");
      conv16(16'd9999, "v9999");
      conv16(16'd10000, "v10000");
      conv16(16'd1000, "v1000");

      start16(16'd255);
      wait_done16(n);
      chk("bp_latency", 32'(n), 32'd16);
      held = bcd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         bin = 16'd1234;
         check16(16'd255, "bp_hold");
         chk("bp_in_ready", 32'(in_ready5), 32'd0);
      end
      @(negedge clk);
      bin = 16'd7;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("bp_release_valid", 32'(out_valid5), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready5), 32'd1);
      chk("bp_keep_bcd", 32'(bcd5), 32'(held));
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_accept_next", 32'(in_ready5), 32'd0);
      wait_done16(n);
      chk("bp_next_latency", 32'(n), 32'd16);
      check16(16'd7, "bp_next");
      pop16("bp_next");

      start16(16'd999);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid5), 32'd0);
      chk("midrst_bcd", 32'(bcd5), 32'd0);
      chk("midrst_ovf", 32'(overflow5), 32'd0);
      chk("midrst_in_ready", 32'(in_ready5), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      conv16(16'd42, "v42");

      for (int i = 0; i < 1500; i++) conv16(16'($urandom), "rnd16");
      for (int v = 0; v < 256; v++) conv8(8'(v));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
